outlier_fifo_reader: RTL and testbench

//  Consumer end of the validator controller's outlier FIFO (fifo_generator_0, standard read mode).
//  - Pops outlier point positions with read_fifo/empty and forwards them as a valid/ready stream with m_last on the final outlier.
//  - Counts outliers and reports when the whole point cloud has been drained, so a DMA or host bridge gets one framed packet per cloud.

---
 rtl/outlier_fifo_reader.sv | 154 +++++++++++++++
 tb/tb_outlier_fifo_reader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outlier_fifo_reader.sv
// Outlier FIFO consumer: pops positions and emits a framed valid/ready stream.
// Optional RANGE_CHECK_EN drops positions outside 1..point_cloud_size.
module outlier_fifo_reader #(
  parameter int N        = 16,
  parameter int CNT_W    = 32,
  parameter int READ_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             controller_done,
  input  logic             fifo_empty,
  input  logic [N-1:0]     outlier_pos_fifo,
  output logic             read_fifo,
  input  logic [2*N-1:0]   point_cloud_size,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N-1:0]     m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] outlier_count,
  output logic [CNT_W-1:0] range_err_count,
  output logic             busy,
  output logic             finished
);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t       state, state_nx;
  logic [N-1:0] buf0, buf1;
  logic [1:0]   occ;
  logic         inflight;
  logic [1:0]   empty_run;
  logic         term_ok;
  logic         word_ok;
  logic         push;
  logic         pop;
  logic         restart;
  logic         unused_cfg;

  assign unused_cfg = (READ_LAT != 1);

`ifdef RANGE_CHECK_EN
  logic drop;
  assign word_ok = (outlier_pos_fifo != '0) &&
                   ({{N{1'b0}}, outlier_pos_fifo} <= point_cloud_size);
  assign drop    = inflight && !word_ok;
`else
  logic unused_psize;
  assign unused_psize    = ^point_cloud_size;
  assign word_ok         = 1'b1;
  assign range_err_count = '0;
`endif

  assign term_ok = controller_done && fifo_empty && !inflight &&
                   (empty_run >= 2'd2);
  assign push    = inflight && word_ok;
  assign pop     = m_valid && m_ready;
  assign restart = start && (state != DRAIN);
  assign m_data  = buf0;

  // Next state and presentation logic
  always_comb begin
    state_nx  = state;
    read_fifo = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    busy      = 1'b0;
    finished  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        read_fifo = !fifo_empty &&
                    (({1'b0, occ} + {2'b0, inflight}) < 3'd2);
        m_valid   = (occ == 2'd2) || ((occ == 2'd1) && term_ok);
        m_last    = (occ == 2'd1) && term_ok;
        if (term_ok && (occ == 2'd0)) state_nx = DONE;
      end
      DONE: begin
        finished = 1'b1;
        if (start) state_nx = DRAIN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Two-entry holdback buffer and read-in-flight tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf0     <= '0;
      buf1     <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= read_fifo;
      if (push && pop) begin
        if (occ == 2'd2) begin
          buf0 <= buf1;
          buf1 <= outlier_pos_fifo;
        end else begin
          buf0 <= outlier_pos_fifo;
        end
      end else if (pop) begin
        buf0 <= buf1;
        occ  <= occ - 2'd1;
      end else if (push) begin
        if (occ == 2'd0) buf0 <= outlier_pos_fifo;
        else             buf1 <= outlier_pos_fifo;
        occ <= occ + 2'd1;
      end
    end
  end

  // Beat counter and done/empty persistence tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outlier_count <= '0;
      empty_run     <= 2'd0;
    end else if (restart) begin
      outlier_count <= '0;
      empty_run     <= 2'd0;
    end else begin
      if (pop && (outlier_count != '1))
        outlier_count <= outlier_count + 1'b1;
      if (state == DRAIN) begin
        if (controller_done && fifo_empty)
          empty_run <= (empty_run == 2'd3) ? 2'd3 : empty_run + 2'd1;
        else
          empty_run <= 2'd0;
      end
    end
  end

`ifdef RANGE_CHECK_EN
  // Count positions rejected at buffer write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      range_err_count <= '0;
    else if (restart)
      range_err_count <= '0;
    else if (drop && (range_err_count != '1))
      range_err_count <= range_err_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_outlier_fifo_reader.sv
// Bench for outlier_fifo_reader: FIFO model, stream scoreboard, random clouds.
// Build with +define+RANGE_CHECK_EN to exercise the range filter.
module tb_outlier_fifo_reader;

  localparam int N     = 16;
  localparam int CNT_W = 32;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             controller_done = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [N-1:0]     dout = '0;
  logic             read_fifo;
  logic [2*N-1:0]   psize = 32'd1000;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [N-1:0]     m_data;
  logic             m_last;
  logic [CNT_W-1:0] outlier_count;
  logic [CNT_W-1:0] range_err_count;
  logic             busy;
  logic             finished;

  outlier_fifo_reader #(.N(N), .CNT_W(CNT_W), .READ_LAT(1)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .controller_done  (controller_done),
    .fifo_empty       (fifo_empty),
    .outlier_pos_fifo (dout),
    .read_fifo        (read_fifo),
    .point_cloud_size (psize),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_last           (m_last),
    .outlier_count    (outlier_count),
    .range_err_count  (range_err_count),
    .busy             (busy),
    .finished         (finished)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] fq[$];
  logic [N-1:0] wr_q[$];
  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];
  logic         got_l[$];
  logic [N-1:0] ws[$];
  bit           fifo_clear = 0;
  int           model_cnt = 0;
  int           ready_mode = 0;
  int           cyc = 0;

  // FIFO model: standard read mode, one-cycle dout latency
  always @(posedge clock) begin
    cyc++;
    if (fifo_clear) begin
      fq.delete();
    end else begin
      if (read_fifo) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL fifo_underflow: read_fifo=1 while fifo empty");
        end else begin
          dout <= fq.pop_front();
        end
      end
      while (wr_q.size() > 0) fq.push_back(wr_q.pop_front());
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Sink ready pattern
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 3 == 0);
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  logic         pv = 0;
  logic         pr = 0;
  logic         pl = 0;
  logic [N-1:0] pd = '0;

  // Stream scoreboard, sampled mid-cycle
  always @(negedge clock) begin
    if (!reset_n) begin
      pv = 0;
    end else begin
      checks++;
      if (m_valid && (exp_q.size() == 0 || !busy)) begin
        errors++;
        $display("FAIL unexpected_beat: data=%0d busy=%0b", m_data, busy);
      end else if (m_valid) begin
        if (m_data !== exp_q[0] || m_last !== (exp_q.size() == 1)) begin
          errors++;
          $display("FAIL beat: got data=%0d last=%0b, want data=%0d last=%0b",
                   m_data, m_last, exp_q[0], (exp_q.size() == 1));
        end
      end
      if (pv && !pr) begin
        checks++;
        if (!m_valid || m_data !== pd || m_last !== pl) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0d l=%0b, want v=1 d=%0d l=%0b",
                   m_valid, m_data, m_last, pd, pl);
        end
      end
      checks++;
      if (outlier_count !== 32'(model_cnt)) begin
        errors++;
        $display("FAIL outlier_count: got %0d want %0d", outlier_count, model_cnt);
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      pl = m_last;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_l.push_back(m_last);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        model_cnt++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic bit ok_word(input logic [N-1:0] w);
`ifdef RANGE_CHECK_EN
    return (w != 0) && ({{N{1'b0}}, w} <= psize);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input bit ok, input int got, input int want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic run_cloud(input int mode, input bit late, output int fin_cyc);
    int exp_err;
    int n_ok;
    exp_err = 0;
    n_ok = 0;
    ready_mode = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_cnt = 0;
    exp_q.delete();
    got_q.delete();
    got_l.delete();
    foreach (ws[i]) begin
      if (ok_word(ws[i])) begin
        exp_q.push_back(ws[i]);
        n_ok++;
      end else begin
        exp_err++;
      end
    end
    if (!late) begin
      foreach (ws[i]) begin
        wr_q.push_back(ws[i]);
        tick();
      end
      tick(2);
      controller_done = 1'b1;
    end else begin
      controller_done = 1'b1;
      foreach (ws[i]) wr_q.push_back(ws[i]);
    end
    fin_cyc = 0;
    while (!finished && fin_cyc < 400) begin
      tick();
      fin_cyc++;
    end
    check("finish_timeout", finished === 1'b1, fin_cyc, 400);
    check("final_count", outlier_count === 32'(n_ok), int'(outlier_count), n_ok);
    check("range_err", range_err_count === 32'(exp_err), int'(range_err_count), exp_err);
    check("beats_missing", exp_q.size() == 0, exp_q.size(), 0);
    check("busy_at_done", busy === 1'b0, int'(busy), 0);
    controller_done = 1'b0;
  endtask

  int fc;
  int k;

  initial begin
    #2;
    check("reset_outputs",
          {read_fifo, m_valid, m_data, m_last, busy, finished} === '0 &&
          outlier_count === '0 && range_err_count === '0, int'(m_valid), 0);
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Basic three-word cloud
    ws.delete();
    ws.push_back(16'd3); ws.push_back(16'd7); ws.push_back(16'd9);
    run_cloud(0, 0, fc);
    check("t1_beats", got_q.size() == 3 && got_q[0] == 3 && got_q[1] == 7 &&
          got_q[2] == 9, got_q.size(), 3);
    check("t1_last", got_l.size() == 3 && got_l[0] == 0 && got_l[1] == 0 &&
          got_l[2] == 1, got_l.size(), 3);
    check("t1_count", outlier_count === 32'd3, int'(outlier_count), 3);

    // Zero outliers
    ws.delete();
    run_cloud(0, 1, fc);
    check("t2_latency", fc <= 4, fc, 4);
    check("t2_nobeats", got_q.size() == 0, got_q.size(), 0);

    // Backpressure
    ws.delete();
    for (int i = 0; i < 5; i++) ws.push_back(16'(100 + i));
    run_cloud(1, 0, fc);
    check("t3_order", got_q.size() == 5 && got_q[0] == 100 && got_q[4] == 104,
          got_q.size(), 5);

    // Late write after done
    ws.delete();
    ws.push_back(16'd12);
    run_cloud(0, 1, fc);
    check("t4_beat", got_q.size() == 1 && got_q[0] == 12 && got_l[0] == 1,
          got_q.size(), 1);

    // Reset in the middle of a drain with a full buffer
    ws.delete();
    for (int i = 0; i < 5; i++) ws.push_back(16'(20 + i));
    ready_mode = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_cnt = 0;
    exp_q.delete();
    foreach (ws[i]) begin
      exp_q.push_back(ws[i]);
      wr_q.push_back(ws[i]);
    end
    k = 0;
    while (!m_valid && k < 20) begin
      tick();
      k++;
    end
    check("t5_fill", m_valid === 1'b1, k, 20);
    tick(2);
    reset_n = 1'b0;
    #1;
    check("t5_reset_outputs",
          {read_fifo, m_valid, m_data, m_last, busy, finished} === '0 &&
          outlier_count === '0 && range_err_count === '0, int'(m_data), 0);
    exp_q.delete();
    model_cnt = 0;
    fifo_clear = 1;
    tick();
    fifo_clear = 0;
    tick();
    reset_n = 1'b1;
    tick();
    check("t5_idle", busy === 1'b0 && finished === 1'b0, int'(busy), 0);
    ws.delete();
    ws.push_back(16'd5); ws.push_back(16'd6);
    run_cloud(2, 0, fc);
    check("t5_clean", got_q.size() == 2 && got_q[0] == 5 && got_q[1] == 6,
          got_q.size(), 2);

    // Range filter
    psize = 32'd10;
    ws.delete();
    ws.push_back(16'd4); ws.push_back(16'd0);
    ws.push_back(16'd11); ws.push_back(16'd10);
    run_cloud(0, 0, fc);
`ifdef RANGE_CHECK_EN
    check("t6_beats", got_q.size() == 2 && got_q[0] == 4 && got_q[1] == 10 &&
          got_l[1] == 1, got_q.size(), 2);
    check("t6_errs", range_err_count === 32'd2, int'(range_err_count), 2);
`else
    check("t6_beats", got_q.size() == 4 && got_q[1] == 0 && got_q[2] == 11 &&
          got_l[3] == 1, got_q.size(), 4);
    check("t6_errs", range_err_count === 32'd0, int'(range_err_count), 0);
`endif

    // Random clouds
    for (int r = 0; r < 12; r++) begin
      psize = 32'($urandom_range(5, 60));
      ws.delete();
      for (int i = 0; i < int'($urandom_range(0, 7)); i++) begin
        if ($urandom_range(0, 5) == 0) ws.push_back(16'($urandom_range(0, 70)));
        else ws.push_back(16'($urandom_range(1, int'(psize))));
      end
      run_cloud(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), fc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
